// File: rtl/fir_tap_accumulator.sv
// Sums NUM_TAPS signed tap products per sample, then rounds, shifts and saturates the sum.
// Three register stages (sum, round, output buffer); the product stream is never stalled.
module fir_tap_accumulator #(
  parameter int PROD_WIDTH     = 34,
  parameter int NUM_TAPS       = 16,
  parameter int ACC_WIDTH      = 38,
  parameter int SHIFT          = 13,
  parameter int OUT_DATA_WIDTH = 21
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PROD_WIDTH-1:0]        prod_data,
  input  logic                         prod_vld,
  input  logic                         frame_clr,
  output logic [OUT_DATA_WIDTH-1:0]    out_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         out_sat,
  output logic                         overrun,
  output logic [$clog2(NUM_TAPS)-1:0]  tap_cnt
);

  localparam int TW = $clog2(NUM_TAPS);
  localparam int RW = ACC_WIDTH + 1;
  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);
  localparam logic signed [RW-1:0] RND_C = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] OMAX =
    {{(RW-OUT_DATA_WIDTH+1){1'b0}}, {(OUT_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN =
    {{(RW-OUT_DATA_WIDTH+1){1'b1}}, {(OUT_DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]      acc_q, acc_d, prod_ext, acc_sum;
  logic [TW-1:0]                    tap_cnt_q, tap_cnt_d;
  logic signed [ACC_WIDTH-1:0]      sum_q, sum_d;
  logic                             sum_vld_q, sum_vld_d;
  logic signed [RW-1:0]             rnd_full, rnd_shr;
  logic [OUT_DATA_WIDTH-1:0]        rnd_data_q, rnd_data_d;
  logic                             rnd_sat_q, rnd_sat_d;
  logic                             rnd_vld_q, rnd_vld_d;
  logic [OUT_DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                             out_sat_q, out_sat_d;
  logic                             out_vld_q, out_vld_d;
  logic                             overrun_q, overrun_d;
  logic                             load;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
  assign acc_sum  = acc_q + prod_ext;

  // acc is always zero at tap 0, so adding covers the first-tap load too
  always_comb begin
    acc_d     = acc_q;
    tap_cnt_d = tap_cnt_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    if (frame_clr) begin
      acc_d     = prod_vld ? prod_ext : '0;
      tap_cnt_d = prod_vld ? TW'(1) : '0;
    end else if (prod_vld) begin
      if (tap_cnt_q == LAST_TAP) begin
        sum_d     = acc_sum;
        sum_vld_d = 1'b1;
        acc_d     = '0;
        tap_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
    end
  end

  // One guard bit keeps the half-up add from wrapping
  always_comb begin
    rnd_full   = {sum_q[ACC_WIDTH-1], sum_q} + RND_C;
    rnd_shr    = rnd_full >>> SHIFT;
    rnd_vld_d  = sum_vld_q;
    rnd_data_d = rnd_data_q;
    rnd_sat_d  = rnd_sat_q;
    if (sum_vld_q) begin
      if (rnd_shr > OMAX) begin
        rnd_data_d = OMAX[OUT_DATA_WIDTH-1:0];
        rnd_sat_d  = 1'b1;
      end else if (rnd_shr < OMIN) begin
        rnd_data_d = OMIN[OUT_DATA_WIDTH-1:0];
        rnd_sat_d  = 1'b1;
      end else begin
        rnd_data_d = rnd_shr[OUT_DATA_WIDTH-1:0];
        rnd_sat_d  = 1'b0;
      end
    end
  end

  always_comb begin
    load       = rnd_vld_q && (!out_vld_q || out_rdy);
    out_data_d = load ? rnd_data_q : out_data_q;
    out_sat_d  = load ? rnd_sat_q : out_sat_q;
    out_vld_d  = load || (out_vld_q && !out_rdy);
    overrun_d  = rnd_vld_q && out_vld_q && !out_rdy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      tap_cnt_q  <= '0;
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      rnd_data_q <= '0;
      rnd_sat_q  <= 1'b0;
      rnd_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      tap_cnt_q  <= tap_cnt_d;
      sum_q      <= sum_d;
      sum_vld_q  <= sum_vld_d;
      rnd_data_q <= rnd_data_d;
      rnd_sat_q  <= rnd_sat_d;
      rnd_vld_q  <= rnd_vld_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_vld_q  <= out_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;
  assign out_vld  = out_vld_q;
  assign overrun  = overrun_q;
  assign tap_cnt  = tap_cnt_q;

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench for fir_tap_accumulator (4 taps, shift 2): expected samples queued at issue,
// popped and compared by a monitor whenever the output handshake completes.
module tb_fir_tap_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [33:0] prod_data;
  logic               prod_vld;
  logic               frame_clr;
  logic [20:0]        out_data;
  logic               out_vld;
  logic               out_rdy;
  logic               out_sat;
  logic               overrun;
  logic [1:0]         tap_cnt;

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e;
  int     checks = 0;
  int     errors = 0;
  int     out_cnt = 0;
  int     ovr_cnt = 0;
  bit     hold_vld = 1'b0;
  longint hold_data = 0;

  localparam longint PMAX = 64'sd8589737985;

  fir_tap_accumulator #(
    .PROD_WIDTH(34), .NUM_TAPS(4), .ACC_WIDTH(36), .SHIFT(2), .OUT_DATA_WIDTH(21)
  ) dut (
    .clk(clk), .reset(rst_n), .prod_data(prod_data), .prod_vld(prod_vld),
    .frame_clr(frame_clr), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_sat(out_sat), .overrun(overrun), .tap_cnt(tap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input longint p);
    prod_vld  = 1'b1;
    prod_data = p[33:0];
    tick();
  endtask

  task automatic idle_n(input int n);
    prod_vld  = 1'b0;
    prod_data = 'x;
    repeat (n) tick();
  endtask

  task automatic push(input longint d, input bit s);
    exp_t x;
    x.d = d;
    x.s = s;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (overrun) ovr_cnt++;
      if (hold_vld) begin
        check("hold_vld", longint'(out_vld), 1);
        check("hold_data", longint'($signed(out_data)), hold_data);
      end
      if (out_vld && out_rdy) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0d, expected no sample", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'($signed(out_data)), e.d);
          check("out_sat", longint'(out_sat), longint'(e.s));
        end
      end
      hold_vld  = out_vld && !out_rdy;
      hold_data = longint'($signed(out_data));
    end
  end

  initial begin
    rst_n     = 1'b0;
    prod_vld  = 1'b0;
    prod_data = '0;
    frame_clr = 1'b0;
    out_rdy   = 1'b1;
    #3;
    check("rst_out_vld", longint'(out_vld), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_overrun", longint'(overrun), 0);
    check("rst_tap_cnt", longint'(tap_cnt), 0);
    tick();
    rst_n = 1'b1;
    idle_n(2);

    // 1: basic sum, latency
    push(25, 0);
    send(10);
    check("tap_cnt_1", longint'(tap_cnt), 1);
    send(20);
    send(30);
    send(40);
    idle_n(0);
    check("tap_cnt_wrap", longint'(tap_cnt), 0);
    check("lat_edge0", longint'(out_vld), 0);
    tick();
    check("lat_edge1", longint'(out_vld), 0);
    tick();
    check("lat_edge2", longint'(out_vld), 1);
    idle_n(3);

    // 2: negative rounding
    push(-7, 0);
    repeat (4) send(-7);
    idle_n(4);

    // 3: saturation both ways, back to back
    push(1048575, 1);
    push(-1048576, 1);
    repeat (4) send(PMAX);
    repeat (4) send(-PMAX);
    idle_n(6);

    // 4: stalled output, second frame dropped
    out_rdy = 1'b0;
    push(3, 0);
    send(1); send(2); send(3); send(4);
    send(5); send(6); send(7); send(8);
    idle_n(6);
    check("ovr_count", longint'(ovr_cnt), 1);
    check("held_vld", longint'(out_vld), 1);
    check("held_data", longint'($signed(out_data)), 3);
    out_rdy = 1'b1;
    tick();
    check("vld_after_accept", longint'(out_vld), 0);
    idle_n(2);

    // 5: frame_clr with simultaneous product
    push(4, 0);
    send(100);
    send(100);
    frame_clr = 1'b1;
    send(4);
    frame_clr = 1'b0;
    check("tap_cnt_clr", longint'(tap_cnt), 1);
    send(4); send(4); send(4);
    idle_n(5);

    // 6: async reset mid-frame
    send(7); send(7); send(7);
    idle_n(0);
    check("tap_cnt_pre_rst", longint'(tap_cnt), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tap_cnt", longint'(tap_cnt), 0);
    check("mid_rst_out_vld", longint'(out_vld), 0);
    tick();
    rst_n = 1'b1;
    idle_n(1);
    send(1); send(1); send(1);
    idle_n(3);
    check("no_early_out", longint'(out_vld), 0);
    check("out_cnt_pre", longint'(out_cnt), 6);
    push(1, 0);
    send(1);
    idle_n(6);

    check("queue_empty", longint'(exp_q.size()), 0);
    check("out_cnt_total", longint'(out_cnt), 7);
    check("ovr_total", longint'(ovr_cnt), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
